// File: rtl/pwm_symbol_encoder_pkg.sv
// Shared definitions for the PWM symbol encoder: project-wide defaults for
// the symbol length, sample width and idle duty, plus the encoder state type.
package pwm_symbol_encoder_pkg;

  localparam int unsigned PWM_STEPS_DEFAULT    = 64;
  localparam int unsigned SAMPLE_WIDTH_DEFAULT = 8;
  localparam int unsigned IDLE_DUTY_DEFAULT    = PWM_STEPS_DEFAULT / 2;

  // PRIME: waiting for enough buffered samples; RUN: streaming samples.
  typedef enum logic {
    ST_PRIME = 1'b0,
    ST_RUN   = 1'b1
  } enc_state_e;

endpackage

// File: rtl/pwm_symbol_encoder_sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   push, wdata   write request and data (ignored while full)
//   pop           read request (ignored while empty)
//   rdata         head entry, valid whenever !empty
//   full, empty   occupancy flags
//   count         current occupancy, $clog2(DEPTH)+1 bits
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  // Full refuses a push even when a pop happens in the same cycle.
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    // DEPTH is a power of two, so pointers wrap by natural overflow.
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries data only and needs no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/pwm_symbol_encoder.sv
// pwm_symbol_encoder: buffers streamed audio samples and, on each symbol
// request from the PWM modulator, emits one MSB-first thermometer word.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   s_data/s_valid/s_ready    sample input handshake
//   symb_req                  one-cycle request for the next symbol
//   symb_word, symb_duty      registered thermometer word and its duty count
//   symb_valid                pulse: symb_word/symb_duty updated this cycle
//   underrun, underrun_cnt    pulse and saturating count of starved requests
//   fill_level                current FIFO occupancy
module pwm_symbol_encoder
  import pwm_symbol_encoder_pkg::*;
#(
  parameter int unsigned AM_PWM_STEPS = PWM_STEPS_DEFAULT,
  parameter int unsigned SAMPLE_WIDTH = SAMPLE_WIDTH_DEFAULT,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned PREFILL      = 4,
  parameter int unsigned IDLE_DUTY    = AM_PWM_STEPS / 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [SAMPLE_WIDTH-1:0]       s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic                          symb_req,
  output logic [AM_PWM_STEPS-1:0]       symb_word,
  output logic [$clog2(AM_PWM_STEPS):0] symb_duty,
  output logic                          symb_valid,
  output logic                          underrun,
  output logic [15:0]                   underrun_cnt,
  output logic [$clog2(FIFO_DEPTH):0]   fill_level
);

  localparam int unsigned DUTY_W = $clog2(AM_PWM_STEPS);
  localparam int unsigned FILL_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [DUTY_W:0] IDLE_DUTY_V = (DUTY_W + 1)'(IDLE_DUTY);

  // Top 'duty' bits set: shifting an all-ones vector right by duty leaves
  // exactly the low bits that must be cleared.
  function automatic logic [AM_PWM_STEPS-1:0] thermo(input logic [DUTY_W:0] duty);
    return ~({AM_PWM_STEPS{1'b1}} >> duty);
  endfunction

  enc_state_e                state_q, state_d;
  logic [AM_PWM_STEPS-1:0]   symb_word_q, symb_word_d;
  logic [DUTY_W:0]           symb_duty_q, symb_duty_d;
  logic                      symb_valid_q, symb_valid_d;
  logic                      underrun_q, underrun_d;
  logic [15:0]               underrun_cnt_q, underrun_cnt_d;

  logic [SAMPLE_WIDTH-1:0]   fifo_rdata;
  logic                      fifo_full, fifo_empty, fifo_pop;
  logic [FILL_W-1:0]         fifo_count;
  logic [DUTY_W:0]           sample_duty;

  // Ready is held low during reset, otherwise it tracks "not full".
  assign s_ready     = !rst && !fifo_full;
  assign sample_duty = {1'b0, fifo_rdata[SAMPLE_WIDTH-1 -: DUTY_W]};

  sync_fifo #(
    .WIDTH (SAMPLE_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (s_valid && s_ready),
    .wdata (s_data),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // State register together with the registered symbol outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_PRIME;
      symb_word_q    <= thermo(IDLE_DUTY_V);
      symb_duty_q    <= IDLE_DUTY_V;
      symb_valid_q   <= 1'b0;
      underrun_q     <= 1'b0;
      underrun_cnt_q <= '0;
    end else begin
      state_q        <= state_d;
      symb_word_q    <= symb_word_d;
      symb_duty_q    <= symb_duty_d;
      symb_valid_q   <= symb_valid_d;
      underrun_q     <= underrun_d;
      underrun_cnt_q <= underrun_cnt_d;
    end
  end

  // Next state: prefill level is checked every cycle, not only on requests.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_PRIME: if (fifo_count >= FILL_W'(PREFILL)) state_d = ST_RUN;
      ST_RUN:   if (symb_req && fifo_empty)        state_d = ST_PRIME;
      default:  state_d = ST_PRIME;
    endcase
  end

  // Outputs: every request yields a symbol; only RUN consumes samples.
  // No bypass path, so a same-cycle push into an empty FIFO cannot serve it.
  always_comb begin
    fifo_pop       = 1'b0;
    symb_valid_d   = 1'b0;
    underrun_d     = 1'b0;
    symb_word_d    = symb_word_q;
    symb_duty_d    = symb_duty_q;
    underrun_cnt_d = underrun_cnt_q;
    if (symb_req) begin
      symb_valid_d = 1'b1;
      symb_duty_d  = IDLE_DUTY_V;
      symb_word_d  = thermo(IDLE_DUTY_V);
      if (state_q == ST_RUN) begin
        if (!fifo_empty) begin
          fifo_pop    = 1'b1;
          symb_duty_d = sample_duty;
          symb_word_d = thermo(sample_duty);
        end else begin
          underrun_d = 1'b1;
          if (underrun_cnt_q != 16'hFFFF) underrun_cnt_d = underrun_cnt_q + 16'd1;
        end
      end
    end
  end

  assign symb_word    = symb_word_q;
  assign symb_duty    = symb_duty_q;
  assign symb_valid   = symb_valid_q;
  assign underrun     = underrun_q;
  assign underrun_cnt = underrun_cnt_q;
  assign fill_level   = fifo_count;

endmodule

// File: tb/tb_pwm_symbol_encoder.sv
// Bench for pwm_symbol_encoder with default parameters (64 steps, 8-bit
// samples, depth 8, prefill 4). A queue-based model predicts every output
// each cycle; directed phases add literal expectations.
module tb_pwm_symbol_encoder;

  localparam int STEPS   = 64;
  localparam int DEPTH   = 8;
  localparam int PREFILL = 4;
  localparam int IDLE    = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  s_data = '0;
  logic        s_valid = 1'b0;
  logic        symb_req = 1'b0;
  logic        s_ready;
  logic [63:0] symb_word;
  logic [6:0]  symb_duty;
  logic        symb_valid;
  logic        underrun;
  logic [15:0] underrun_cnt;
  logic [3:0]  fill_level;

  pwm_symbol_encoder dut (
    .clk          (clk),
    .rst          (rst),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .symb_req     (symb_req),
    .symb_word    (symb_word),
    .symb_duty    (symb_duty),
    .symb_valid   (symb_valid),
    .underrun     (underrun),
    .underrun_cnt (underrun_cnt),
    .fill_level   (fill_level)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] mq[$];
  bit         m_run = 1'b0;
  int         m_duty = IDLE;
  bit         m_vld = 1'b0;
  bit         m_ur = 1'b0;
  int         m_cnt = 0;
  bit         started = 1'b0;
  int         ovr_seq = 0;
  int         ovr_seen = 0;

  always @(posedge clk) begin
    int pre_size;
    bit was_full;
    bit nxt_run;
    pre_size = mq.size();
    was_full = (pre_size == DEPTH);
    nxt_run  = m_run;
    if (rst) begin
      mq.delete();
      m_run  = 1'b0;
      m_duty = IDLE;
      m_vld  = 1'b0;
      m_ur   = 1'b0;
      m_cnt  = 0;
    end else begin
      if (ovr_seq != ovr_seen) begin
        m_cnt    = 'hFFFE;
        ovr_seen = ovr_seq;
      end
      m_vld = symb_req;
      m_ur  = 1'b0;
      if (!m_run && pre_size >= PREFILL) nxt_run = 1'b1;
      if (symb_req) begin
        if (m_run && pre_size > 0) begin
          m_duty = int'(mq.pop_front() >> 2);
        end else begin
          m_duty = IDLE;
          if (m_run) begin
            m_ur = 1'b1;
            if (m_cnt < 65535) m_cnt++;
            nxt_run = 1'b0;
          end
        end
      end
      if (s_valid && !was_full) mq.push_back(s_data);
      m_run = nxt_run;
    end
    started = 1'b1;
  end

  // ---------------- per-cycle comparison ----------------
  always @(posedge clk) begin
    logic [63:0] w;
    #1;
    if (started) begin
      for (int i = 0; i < STEPS; i++) w[63 - i] = (i < m_duty);
      chk("symb_valid",   64'(symb_valid),   64'(m_vld));
      chk("underrun",     64'(underrun),     64'(m_ur));
      chk("underrun_cnt", 64'(underrun_cnt), 64'(m_cnt));
      chk("fill_level",   64'(fill_level),   64'(mq.size()));
      chk("s_ready",      64'(s_ready),      64'(!rst && mq.size() < DEPTH));
      chk("symb_duty",    64'(symb_duty),    64'(m_duty));
      chk("symb_word",    symb_word,         w);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic push(input logic [7:0] d);
    s_data  = d;
    s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic req();
    symb_req = 1'b1;
    @(negedge clk);
    symb_req = 1'b0;
  endtask

  task automatic cause_underrun(input int base);
    for (int i = 0; i < 4; i++) push(8'(base + i * 29));
    @(negedge clk);
    repeat (5) req();
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_fill",   64'(fill_level),   64'd0);
    chk("rst_duty",   64'(symb_duty),    64'd32);
    chk("rst_valid",  64'(symb_valid),   64'd0);
    chk("rst_cnt",    64'(underrun_cnt), 64'd0);
    chk("rst_ready",  64'(s_ready),      64'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 64'(s_ready), 64'd1);

    // Priming: requests with an empty FIFO emit idle duty, no underrun.
    repeat (3) begin
      req();
      chk("prime_valid", 64'(symb_valid), 64'd1);
      chk("prime_duty",  64'(symb_duty),  64'd32);
      chk("prime_word",  symb_word,       64'hFFFFFFFF00000000);
      chk("prime_ur",    64'(underrun),   64'd0);
    end

    // Prefill then stream four samples.
    push(8'h00); push(8'h80); push(8'hFF); push(8'h40);
    @(negedge clk);
    req();
    chk("s0_duty", 64'(symb_duty), 64'd0);
    chk("s0_word", symb_word,      64'h0);
    req();
    chk("s1_duty", 64'(symb_duty), 64'd32);
    chk("s1_word", symb_word,      64'hFFFFFFFF00000000);
    req();
    chk("s2_duty", 64'(symb_duty), 64'd63);
    chk("s2_word", symb_word,      64'hFFFFFFFFFFFFFFFE);
    req();
    chk("s3_duty", 64'(symb_duty), 64'd16);
    chk("s3_word", symb_word,      64'hFFFF000000000000);
    @(negedge clk);
    chk("hold_valid", 64'(symb_valid), 64'd0);
    chk("hold_duty",  64'(symb_duty),  64'd16);

    // Fill to full with s_valid held, then a 9th sample plus a pop.
    s_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s_data = 8'(i * 37 + 8);
      @(negedge clk);
    end
    chk("full_ready", 64'(s_ready),    64'd0);
    chk("full_fill",  64'(fill_level), 64'd8);
    s_data   = 8'hA5;
    symb_req = 1'b1;
    #1;
    chk("full_pop_ready", 64'(s_ready), 64'd0);
    @(negedge clk);
    symb_req = 1'b0;
    chk("after_pop_fill",  64'(fill_level), 64'd7);
    chk("after_pop_ready", 64'(s_ready),    64'd1);
    @(negedge clk);
    s_valid = 1'b0;
    chk("ninth_accepted", 64'(fill_level), 64'd8);

    // Drain, then one starved request.
    repeat (8) req();
    req();
    chk("ur_pulse", 64'(underrun),     64'd1);
    chk("ur_cnt",   64'(underrun_cnt), 64'd1);
    chk("ur_duty",  64'(symb_duty),    64'd32);
    repeat (2) begin
      req();
      chk("no_more_ur", 64'(underrun), 64'd0);
    end

    // Mixed traffic pattern.
    for (int i = 0; i < 40; i++) begin
      s_valid  = (i % 3 != 0);
      s_data   = 8'(i * 53 + 3);
      symb_req = (i % 4 == 1);
      @(negedge clk);
    end
    s_valid  = 1'b0;
    symb_req = 1'b0;
    repeat (12) req();

    // Counter saturation.
    force dut.underrun_cnt_q = 16'hFFFE;
    ovr_seq++;
    @(negedge clk);
    release dut.underrun_cnt_q;
    chk("forced_cnt", 64'(underrun_cnt), 64'hFFFE);
    cause_underrun(17);
    chk("sat_cnt1", 64'(underrun_cnt), 64'hFFFF);
    cause_underrun(101);
    cause_underrun(203);
    chk("sat_cnt3", 64'(underrun_cnt), 64'hFFFF);

    // Reset mid-operation with a request pending.
    for (int i = 0; i < 5; i++) push(8'(i * 45 + 9));
    chk("pre_rst_fill", 64'(fill_level), 64'd5);
    rst      = 1'b1;
    symb_req = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
    symb_req = 1'b0;
    chk("mrst_fill",  64'(fill_level),   64'd0);
    chk("mrst_valid", 64'(symb_valid),   64'd0);
    chk("mrst_duty",  64'(symb_duty),    64'd32);
    chk("mrst_cnt",   64'(underrun_cnt), 64'd0);
    push(8'hFC);
    req();
    chk("mrst_prime_duty", 64'(symb_duty), 64'd32);
    chk("mrst_prime_ur",   64'(underrun),  64'd0);
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_symbol_encoder.md
Name: pwm_symbol_encoder

Overview:
- Upstream stage of the AM PWM modulator. Accepts audio samples over a valid/ready handshake and buffers them in a small FIFO.
- On each PWM-symbol request from the modulator (its symbol terminal-count tick), pops one sample and converts it to an AM_PWM_STEPS-bit thermometer word, MSB-first, ready for loading into the modulator's shift register.
- Replaces the hardcoded sine table in the modulator with streamed data.

Parameters:
- AM_PWM_STEPS, 64, bits per PWM symbol; power of two, 4..256.
- SAMPLE_WIDTH, 8, input sample width; must be >= log2(AM_PWM_STEPS).
- FIFO_DEPTH, 8, sample buffer entries; power of two, >= 2.
- PREFILL, 4, FIFO occupancy needed before streaming starts; 1..FIFO_DEPTH.
- IDLE_DUTY, AM_PWM_STEPS/2, duty emitted while priming or on underrun.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- s_data  in  SAMPLE_WIDTH  unsigned sample.
- s_valid  in  1  sample valid.
- s_ready  out  1  block can accept a sample.
- symb_req  in  1  one-cycle pulse from the modulator: next symbol needed.
- symb_word  out  AM_PWM_STEPS  thermometer word; the top symb_duty bits are 1.
- symb_duty  out  log2(AM_PWM_STEPS)+1  duty count for symb_word.
- symb_valid  out  1  one-cycle pulse; symb_word and symb_duty updated this cycle.
- underrun  out  1  one-cycle pulse: symbol request found the FIFO empty while in RUN.
- underrun_cnt  out  16  saturating underrun counter.
- fill_level  out  log2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset values: FIFO empty; state PRIME; s_ready=0 during the reset cycle, then 1 (not full); symb_word = IDLE_DUTY thermometer; symb_duty = IDLE_DUTY; symb_valid, underrun = 0; underrun_cnt = 0; fill_level = 0.
- Push: a sample is written when s_valid && s_ready. s_ready = !full, registered-free and combinational from the occupancy register. When the FIFO is full, pushes are refused even if a pop occurs in the same cycle.
- Pop: occurs only on symb_req while the state is RUN and the FIFO is not empty. There is no bypass: a push and a symb_req on an empty FIFO in the same cycle counts as an underrun, and the sample is stored.
- Simultaneous push and pop on a FIFO that is neither empty nor full: occupancy is unchanged.
- Conversion: duty = s_data[SAMPLE_WIDTH-1 -: log2(AM_PWM_STEPS)] (truncate, no rounding), range 0..AM_PWM_STEPS-1. symb_word[AM_PWM_STEPS-1 -: duty] = 1 and all remaining bits = 0. duty 0 gives an all-zero word.
- Latency: symb_word, symb_duty and symb_valid are registered, valid the cycle after symb_req. They hold their value until the next symb_req.
- State machine:
  - PRIME: every symb_req emits IDLE_DUTY with symb_valid=1; no underrun is flagged. Move to RUN when fill_level >= PREFILL (evaluated every cycle).
  - RUN, symb_req with FIFO non-empty: pop and emit the converted sample.
  - RUN, symb_req with FIFO empty: emit IDLE_DUTY, pulse underrun, increment underrun_cnt (saturates at 16'hFFFF), and return to PRIME.
- symb_req is ignored in the reset cycle.
- Reset mid-operation flushes the FIFO and restores every reset value in the following cycle.
- Pointers wrap modulo FIFO_DEPTH. Occupancy is tracked with an explicit counter of log2(FIFO_DEPTH)+1 bits.

Decomposition:
- Shared project defines: AM_PWM_STEPS default, sample width, idle duty.
- Local parameters: duty width, pointer width.
- One sub-module: sync_fifo (parameterised width/depth, push/pop/full/empty/count), reusable elsewhere.
- The thermometer conversion is a function inside pwm_symbol_encoder.

Test Plan:
- After reset, issue symb_req x3 with no samples -> 3 symb_valid pulses with symb_duty=32 and symb_word=0xFFFFFFFF00000000; underrun=0; state stays PRIME.
- Push 0x00, 0x80, 0xFF, 0x40 (PREFILL=4), then symb_req x4 -> symb_duty 0, 32, 63, 16 in order; words 0x0, 0xFFFFFFFF00000000, 0xFFFFFFFFFFFFFFFE, 0xFFFF000000000000; each appears the cycle after its request.
- Push 8 samples with s_valid held high -> s_ready drops after the 8th; a 9th sample is held. A symb_req on the same cycle the 9th is presented leaves s_ready low; the 9th is accepted the following cycle.
- In RUN, drain the FIFO, then one extra symb_req -> underrun pulse, underrun_cnt=1, symb_duty=32, state PRIME. Subsequent requests produce no further underruns until 4 samples are refilled.
- Force underrun_cnt to 16'hFFFE, cause 3 underruns -> counter holds at 16'hFFFF.
- Assert rst while fill_level=5 and symb_req is pending -> next cycle fill_level=0, symb_valid=0, symb_duty=32, state PRIME.
